// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, encodings and the IF/ID bundle
// for the instruction-fetch stage.
package if_fetch_unit_pkg;

  localparam int WORD_W = 32;
  localparam int IMEM_AW_DEF = 10;

  typedef logic [WORD_W-1:0] word_bus_t;
  typedef logic [IMEM_AW_DEF-1:0] imem_addr_bus_t;

  localparam word_bus_t NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    word_bus_t instr;
    word_bus_t pc;
    word_bus_t pc4;
    logic      valid;
  } if_id_t;

endpackage

// File: rtl/if_fetch_unit_ifid_reg.sv
// IF/ID pipeline register with hold,
// bubble and load controls.
module ifid_reg
  import if_fetch_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      hold,
  input  logic      bubble,
  input  if_id_t    d,
  output if_id_t    q
);

  // Hold beats bubble beats load; a bubble keeps pc info.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      unique case (1'b1)
        hold: q <= q;
        bubble: begin
          q.instr <= NOP;
          q.pc    <= d.pc;
          q.pc4   <= d.pc4;
          q.valid <= 1'b0;
        end
        default: q <= d;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: PC register, next-PC select
// and BOOT/RUN/FAULT control.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               redirect_valid_i,
  input  logic [31:0]        redirect_pc_i,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [31:0]        imem_data_i,
  output logic [31:0]        pc_o,
  output logic [31:0]        ifid_instr_o,
  output logic [31:0]        ifid_pc_o,
  output logic [31:0]        ifid_pc4_o,
  output logic               ifid_valid_o,
  output logic               fault_o
);

  fetch_state_t state;
  word_bus_t    pc;
  word_bus_t    pc4;
  logic         misaligned;
  logic         run;
  logic         take_fault;
  logic         take_hold;
  logic         take_redir;
  logic         take_flush;
  logic         ifid_hold;
  logic         ifid_bubble;
  if_id_t       ifid_d;
  if_id_t       ifid_q;

  assign pc4 = pc + 32'd4;
  assign misaligned = redirect_valid_i
                    & (redirect_pc_i[1:0] != 2'b00);

  // Mutually exclusive RUN actions in priority order.
  always_comb begin
    run        = (state == RUN);
    take_fault = run & misaligned;
    take_hold  = run & stall_i & ~misaligned;
    take_redir = run & ~stall_i & redirect_valid_i
               & ~misaligned;
    take_flush = run & ~stall_i & ~redirect_valid_i
               & flush_i;
  end

  assign ifid_hold   = (state == BOOT) | take_hold;
  assign ifid_bubble = (state == FAULT) | take_fault
                     | take_redir | take_flush;

  // PC and state; fault flag latches until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      fault_o <= 1'b0;
    end else begin
      unique case (state)
        BOOT: state <= RUN;
        RUN: begin
          unique case (1'b1)
            take_fault: begin
              state   <= FAULT;
              fault_o <= 1'b1;
            end
            take_hold:  pc <= pc;
            take_redir: pc <= redirect_pc_i;
            default:    pc <= pc4;
          endcase
        end
        default: state <= FAULT;
      endcase
    end
  end

  assign ifid_d = '{
    instr: imem_data_i,
    pc:    pc,
    pc4:   pc4,
    valid: 1'b1
  };

  ifid_reg u_ifid (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (ifid_hold),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign imem_addr_o  = pc[IMEM_AW+1:2];
  assign pc_o         = pc;
  assign ifid_instr_o = ifid_q.instr;
  assign ifid_pc_o    = ifid_q.pc;
  assign ifid_pc4_o   = ifid_q.pc4;
  assign ifid_valid_o = ifid_q.valid;

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch initiator for the pipelined MIPS core. It owns the PC and drives the word address of the combinational instruction memory.
- It captures the returned 32-bit instruction into the IF/ID pipeline register.
- It handles stall, flush and branch/jump redirects from the hazard unit and ID stage, and faults on misaligned redirect targets.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
- IMEM_AW, 10, instruction-memory word-address width (1024 words).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  hold PC and IF/ID (load-use hazard).
- flush_i  input  1  load bubble into IF/ID (exception/squash).
- redirect_valid_i  input  1  take redirect_pc_i as the next PC.
- redirect_pc_i  input  32  branch/jump target byte address.
- imem_addr_o  output  IMEM_AW  word address to the instruction memory.
- imem_data_i  input  32  instruction returned by the instruction memory, same cycle.
- pc_o  output  32  current fetch PC.
- ifid_instr_o  output  32  IF/ID instruction.
- ifid_pc_o  output  32  IF/ID PC of that instruction.
- ifid_pc4_o  output  32  IF/ID PC+4.
- ifid_valid_o  output  1  IF/ID holds a real instruction.
- fault_o  output  1  misaligned redirect detected; sticky until reset.

Behaviour:
- Reset is asynchronous on rst_n low:
  - pc = RESET_PC, state = BOOT;
  - ifid_instr = 32'h0, ifid_pc = 0, ifid_pc4 = 0;
  - ifid_valid = 0, fault_o = 0.
- Memory interface:
  - imem_addr_o = pc[IMEM_AW+1:2], purely combinational from the PC register. Upper PC bits are ignored, so addresses wrap modulo 4 KB.
  - The instruction is sampled into IF/ID on the same clock edge that advances the PC. Fetch latency is 1 cycle from PC to IF/ID.
- States:
  - BOOT: one cycle after reset release. IF/ID stays a bubble, PC does not advance. Always goes to RUN next cycle; stall, flush and redirect are ignored in BOOT.
  - RUN: normal fetch.
  - FAULT: PC frozen, IF/ID loads a bubble every cycle, fault_o = 1. Exited only by reset.
- RUN, per rising edge, priority high to low:
  1. redirect_valid_i=1 with redirect_pc_i[1:0]!=0: go to FAULT, pc unchanged, IF/ID = bubble. This takes effect even if stall_i=1.
  2. stall_i=1: pc and all IF/ID outputs hold. flush_i and a legal redirect are ignored; the hazard unit re-asserts them after the stall.
  3. redirect_valid_i=1 (aligned): pc = redirect_pc_i, IF/ID = bubble. There is no delay slot, so the wrong-path fetch is squashed.
  4. flush_i=1: pc = pc+4, IF/ID = bubble.
  5. Otherwise: pc = pc+4, and IF/ID loads {imem_data_i, pc, pc+4, valid=1}.
- Bubble definition: instr = 32'h0000_0000 (sll $0,$0,0), valid = 0. ifid_pc and ifid_pc4 load the current pc and pc+4, for exception reporting.
- pc+4 is a 32-bit add that wraps 32'hFFFF_FFFC -> 0 with no fault.
- Reset asserted mid-operation overrides everything immediately and asynchronously.

Decomposition:
- Shared bus/constant definitions:
  - Word_Bus and IMem_Addr_Bus widths;
  - NOP encoding 32'h0;
  - state encodings BOOT=2'd0, RUN=2'd1, FAULT=2'd2.
- One sub-module, ifid_reg: the IF/ID register with hold/bubble/load controls.
- The PC, next-PC mux and state machine stay in if_fetch_unit.

Test Plan:
- Reset release with RESET_PC=0 and memory word i = 32'h1000_0000+i:
  - cycle 1: BOOT, valid=0;
  - then ifid_instr = 32'h1000_0000, 32'h1000_0001, ... with ifid_pc = 0, 4, 8, ...;
  - imem_addr_o = 0, 1, 2, ....
- stall_i high for 3 cycles at pc=0x10: pc stays 0x10, IF/ID holds the instruction for pc=0x0C. After release, ifid_pc = 0x10 on the next edge.
- redirect_valid_i with redirect_pc_i = 0x40 while pc = 0x14:
  - next cycle: pc = 0x40, ifid_valid = 0;
  - following cycle: ifid_instr = word 16, ifid_pc = 0x40.
- Simultaneous stall_i and aligned redirect to 0x80: pc and IF/ID hold. Redirect is ignored; re-asserting it after the stall gives pc = 0x80.
- Redirect to 0x42: fault_o = 1 next cycle, pc frozen, ifid_valid = 0 indefinitely. Holds even with stall_i=1; cleared only by rst_n=0.
- Wrap and reset:
  - pc = 0xFFC: imem_addr_o = 1023, then pc = 0x1000 with imem_addr_o = 0;
  - rst_n pulsed low mid-fetch: all outputs return to reset values asynchronously.
